// File: rtl/line_fetch_if.sv
// Purpose: framebuffer read port between the line fetcher and the frame memory.
// Latency: none, wires only.
// Backpressure: mem_ready stalls requests; mem_valid returns in order and cannot be stalled.
interface line_fetch_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic        mem_valid;

   modport master (
      output mem_req, mem_addr,
      input  mem_ready, mem_rdata, mem_valid
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ready, mem_rdata, mem_valid
   );
endinterface

// File: rtl/line_fetch.sv
// Purpose: double-buffered scanline fetcher; prefetches the next low-res row in blanking while the current row is displayed.
// Latency: pixel, syncs and de are registered, exactly 1 cycle from the timing inputs; a row fetch spans the trigger line's blanking.
// Backpressure: mem_req holds until mem_ready; returns are never stalled, a fetch still running at the swap point flags underrun and is flushed.
module line_fetch #(
   parameter int H_PIX         = 240,
   parameter int V_ROWS        = 150,
   parameter int H_BLANK_START = 1440,
   parameter int H_LAST        = 1904,
   parameter int V_LAST        = 932
) (
   input  logic              clk,
   input  logic              en,
   input  logic [10:0]       h_counter,
   input  logic [9:0]        v_counter,
   input  logic [8:0]        h_small,
   input  logic [7:0]        v_small,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              can_color_in,
   line_fetch_if.master      mem,
   output logic [7:0]        pixel,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out,
   output logic              underrun
);

   localparam int AW = $clog2(H_PIX);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, FLUSH} state_t;

   state_t         state_q, state_d;
   logic [7:0]     row_q, row_d;
   logic [AW-1:0]  col_q, col_d;
   logic [8:0]     wptr_q, wptr_d;
   logic [8:0]     outst_q, outst_d;
   logic           bank_q, bank_d;
   logic           underrun_q, underrun_d;
   logic [7:0]     pixel_q;
   logic           hsync_q, vsync_q, de_q;

   // Two line buffers; line_mem[bank_q] is displayed, line_mem[~bank_q] is filled.
   logic [7:0]     line_mem [2][H_PIX];

   logic [10:0]    v_trig_line;
   logic           row_line, wrap_line, trig_line;
   logic           trigger, swap;
   logic [7:0]     target_row;
   logic           accept, ret, last_beat, fill_wr, fetch_busy, rd_ok;

   // Line-level decode: which lines fetch, which row, and where the fetch starts and must end.
   always_comb begin
      v_trig_line = 11'(v_small) * 11'd6 + 11'd5;
      row_line    = ({1'b0, v_counter} == v_trig_line) && ((9'(v_small) + 9'd1) < 9'(V_ROWS));
      wrap_line   = (v_counter == 10'(V_LAST));
      trig_line   = row_line || wrap_line;
      trigger     = trig_line && (h_counter == 11'(H_BLANK_START));
      swap        = trig_line && (h_counter == 11'(H_LAST));
      target_row  = wrap_line ? 8'd0 : (v_small + 8'd1);
      accept      = mem.mem_req && mem.mem_ready;
      // A return with nothing outstanding belongs to a fetch abandoned by reset.
      ret         = mem.mem_valid && (outst_q != 9'd0);
      last_beat   = accept && (col_q == AW'(H_PIX - 1));
      fill_wr     = ret && ((state_q == REQ) || (state_q == DRAIN)) && (wptr_q < 9'(H_PIX));
      // DRAIN with a full buffer is finished work, not a late fetch.
      fetch_busy  = (state_q != IDLE) && !((state_q == DRAIN) && (wptr_q == 9'(H_PIX)));
      rd_ok       = can_color_in && (h_small < 9'(H_PIX));
   end

   // Next-state logic; a late fetch at the swap point overrides normal progress.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (trigger) state_d = REQ;
         REQ:   if (last_beat) state_d = DRAIN;
         DRAIN: if (wptr_q == 9'(H_PIX)) state_d = IDLE;
         FLUSH: if (outst_q == 9'd0) state_d = IDLE;
      endcase
      if (swap && fetch_busy) state_d = FLUSH;
   end

   // Datapath next-state: fetch position, fill pointer, outstanding count, bank and underrun.
   always_comb begin
      row_d      = row_q;
      col_d      = col_q;
      wptr_d     = wptr_q;
      bank_d     = bank_q;
      underrun_d = underrun_q;
      outst_d    = outst_q + {8'd0, accept} - {8'd0, ret};
      if ((state_q == IDLE) && trigger) begin
         row_d  = target_row;
         col_d  = '0;
         wptr_d = 9'd0;
      end
      if ((state_q == REQ) && accept && !last_beat) col_d = col_q + AW'(1);
      if (fill_wr) wptr_d = wptr_q + 9'd1;
      if (swap) begin
         bank_d = ~bank_q;
         if (fetch_busy) underrun_d = 1'b1;
      end
      if (trigger && (state_q != IDLE)) underrun_d = 1'b1;
   end

   // Outputs: request while in REQ, address from the current row/column.
   always_comb begin
      mem.mem_req  = (state_q == REQ);
      mem.mem_addr = 16'(row_q) * 16'(H_PIX) + 16'(col_q);
   end

   // State and pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!en) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         wptr_q     <= '0;
         outst_q    <= '0;
         bank_q     <= 1'b0;
         underrun_q <= 1'b0;
         pixel_q    <= '0;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         de_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         wptr_q     <= wptr_d;
         outst_q    <= outst_d;
         bank_q     <= bank_d;
         underrun_q <= underrun_d;
         pixel_q    <= rd_ok ? line_mem[bank_q][h_small[AW-1:0]] : 8'd0;
         hsync_q    <= hsync_in;
         vsync_q    <= vsync_in;
         de_q       <= can_color_in;
      end
   end

   // Fill-buffer write port; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (en && fill_wr) line_mem[~bank_q][wptr_q[AW-1:0]] <= mem.mem_rdata;
   end

   assign pixel     = pixel_q;
   assign hsync_out = hsync_q;
   assign vsync_out = vsync_q;
   assign de_out    = de_q;
   assign underrun  = underrun_q;

endmodule

// File: doc/line_fetch.md
LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have parameters: H_PIX 240, visible low-res pixels per row; V_ROWS 150, visible low-res rows; H_BLANK_START 1440, h_counter value that starts a fetch; H_LAST 1904, last h_counter of a line; V_LAST 932, last v_counter of a frame.
REQ-002 SHALL have ports:
- clk  in  1  pixel clock, all logic on rising edge
- en  in  1  synchronous active-low reset; low = reset
- h_counter  in  11  timing-generator horizontal count
- v_counter  in  10  timing-generator vertical count
- h_small  in  9  low-res column, counter/6
- v_small  in  8  low-res row, counter/6
- hsync_in, vsync_in, can_color_in  in  1 each  timing-generator sync/blank
- mem_req  out  1  framebuffer read request valid
- mem_addr  out  16  read address = row*240 + col
- mem_ready  in  1  request accepted when mem_req && mem_ready
- mem_rdata  in  8  RGB332 read data
- mem_valid  in  1  mem_rdata valid; in-order returns, latency >= 1, no backpressure
- pixel  out  8  RGB332 output
- hsync_out, vsync_out, de_out  out  1 each  syncs and can_color delayed to align with pixel
- underrun  out  1  sticky fetch-late flag

Function
REQ-003 SHALL hold two 240x8 line buffers, display buffer and fill buffer, selected by a 1-bit bank register.
REQ-004 SHALL register pixel, hsync_out, vsync_out and de_out, giving exactly 1 cycle latency from the inputs.
REQ-005 SHALL output pixel = display_buffer[h_small] when can_color_in=1, else pixel = 0, registered.
REQ-006 SHALL define a trigger at h_counter==H_BLANK_START on lines where v_counter == v_small*6+5 and v_small+1 < V_ROWS; target row = v_small+1.
REQ-007 SHALL also trigger at h_counter==H_BLANK_START with v_counter==V_LAST; target row = 0.
REQ-008 SHALL use FSM states IDLE, REQ, DRAIN, FLUSH; a trigger in IDLE loads row and column 0, clears the fill write pointer, and moves to REQ.
REQ-009 In REQ, SHALL assert mem_req with mem_addr = row*240+col and advance col on each accepted beat; after col 239 is accepted, SHALL deassert mem_req and go to DRAIN.
REQ-010 SHALL write each mem_valid beat to fill_buffer[wptr] and increment wptr; from DRAIN, SHALL go to IDLE when wptr reaches 240.
REQ-011 SHALL track outstanding = accepted beats minus returned beats in 9 bits; SHALL never have outstanding greater than 240.
REQ-012 At the swap point (h_counter==H_LAST on a trigger line), SHALL toggle bank so the next line displays the new row.
REQ-013 If the FSM is not IDLE at the swap point, SHALL set underrun, deassert mem_req, and go to FLUSH; FLUSH SHALL discard mem_valid beats without writing either buffer and go to IDLE when outstanding is 0.
REQ-014 SHALL ignore a trigger while not IDLE (no restart); underrun SHALL be set if this occurs.
REQ-015 SHALL compute mem_addr as row*240 + col with no overflow; the maximum value is 35999.
REQ-016 A mem_valid beat that arrives with outstanding = 0 SHALL be ignored.

Reset
REQ-017 While en=0, SHALL clear pixel, hsync_out, vsync_out, de_out, mem_req, mem_addr, underrun, bank, row, col, wptr and outstanding, and set FSM = IDLE; line-buffer contents are not reset.
REQ-018 If en drops mid-fetch, SHALL abandon the fetch and discard beats returned after en rises, treating outstanding as 0 per REQ-016.
REQ-019 underrun SHALL clear only on reset.

Verification
REQ-020 Bench SHALL cover these scenarios:
- Alignment: can_color_in=1, h_small=5, display_buffer[5]=0xA3 -> pixel=0xA3, de_out=1 one cycle later; can_color_in=0 -> pixel=0.
- Line fetch, ready always 1, latency 2: v_counter=5, v_small=0, h_counter=1440 -> 240 beats with addresses 240..479; fill buffer holds the data; bank toggles at h_counter=1904; line 6 shows the new row; underrun=0.
- Frame wrap: v_counter=932, h_counter=1440 -> addresses 0..239; bank toggles at end of line 932.
- Last row: v_counter=899 (v_small=149) -> no trigger, no mem_req, bank unchanged.
- Underrun: mem_ready=1 only every 3rd cycle -> fetch incomplete at h_counter=1904 -> underrun=1; late beats discarded; FSM reaches IDLE when outstanding=0.
- Reset mid-fetch: en=0 after 100 accepted beats -> next cycle mem_req=0, all outputs 0; late mem_valid beats ignored; the next trigger fetches normally.
